// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: opcodes, destinations,
// SFR addresses, PSW bit positions and the sequencing FSM state type.
package alu_writeback_pkg;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'h0,
        ALU_ADD  = 4'h1,
        ALU_ADDC = 4'h2,
        ALU_SUBB = 4'h3,
        ALU_MUL  = 4'h4,
        ALU_DIV  = 4'h5,
        ALU_DA   = 4'h6,
        ALU_NOT  = 4'h7,
        ALU_ANL  = 4'h8,
        ALU_ORL  = 4'h9,
        ALU_XRL  = 4'hA,
        ALU_RL   = 4'hB,
        ALU_RLC  = 4'hC,
        ALU_RR   = 4'hD,
        ALU_RRC  = 4'hE,
        ALU_INC  = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_DEST_ACC    = 2'd0,
        WB_DEST_B      = 2'd1,
        WB_DEST_DIRECT = 2'd2,
        WB_DEST_FLAGS  = 2'd3
    } wb_dest_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } wb_state_e;

    localparam logic [7:0] ACC_ADDR = 8'hE0;
    localparam logic [7:0] B_ADDR   = 8'hF0;
    localparam logic [7:0] PSW_ADDR = 8'hD0;

    localparam int PSW_CY = 7;
    localparam int PSW_AC = 6;
    localparam int PSW_OV = 2;
    localparam int PSW_P  = 0;

    localparam int CNT_W = 4;

    function automatic logic op_is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/wb_flag_mask.sv
// Decodes which PSW flags an opcode updates at commit, and whether it is a
// two-result MUL/DIV operation.
module wb_flag_mask
    import alu_writeback_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [1:0] dest,
    output logic       upd_cy,
    output logic       upd_ac,
    output logic       upd_ov,
    output logic       is_muldiv
);

    always_comb begin
        upd_cy    = 1'b0;
        upd_ac    = 1'b0;
        upd_ov    = 1'b0;
        is_muldiv = op_is_muldiv(opcode);
        case (opcode)
            ALU_ADD, ALU_ADDC, ALU_SUBB: begin
                upd_cy = 1'b1;
                upd_ac = 1'b1;
                upd_ov = 1'b1;
            end
            ALU_MUL, ALU_DIV: begin
                upd_cy = 1'b1;
                upd_ov = 1'b1;
            end
            ALU_RRC, ALU_RLC: upd_cy = 1'b1;
            // Logical ops only touch CY when used as a bit/flag operation.
            ALU_ORL, ALU_ANL: upd_cy = (dest == WB_DEST_FLAGS);
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// 8051 ALU writeback stage: times each ALU operation, commits results/flags
// into ACC, B, PSW (or a direct SFR write) and arbitrates against bus writes.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int MULDIV_EXTRA  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wb_start,
    input  logic [3:0] alu_opcode,
    input  logic [1:0] wb_dest,
    input  logic [7:0] wb_addr,
    input  logic [7:0] op_out_1,
    input  logic [7:0] op_out_2,
    input  logic       carry_out,
    input  logic       aux_carry_out,
    input  logic       overflow_out,
    input  logic       sfr_we,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] sfr_wdata,
    output logic [7:0] acc,
    output logic [7:0] b_reg,
    output logic [7:0] psw,
    output logic       carry_in,
    output logic       aux_carry_in,
    output logic       out_we,
    output logic [7:0] out_addr,
    output logic [7:0] out_wdata,
    output logic       wb_busy,
    output logic       wb_done,
    output logic       start_err,
    output logic       sfr_conflict,
    output wb_state_e  fsm_state
);

    // Protocol: wb_start is accepted only in IDLE; wb_busy covers WAIT and
    // COMMIT, and wb_done marks the single COMMIT cycle whose results are
    // visible in the registers on the following cycle.

    wb_state_e          state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [1:0]         dest_q;
    logic [7:0]         addr_q;

    logic upd_cy, upd_ac, upd_ov, is_muldiv;
    logic commit, div_ovf, wr_acc, wr_b, wr_psw;
    logic bus_acc, bus_b, bus_psw, conflict;
    logic [7:0] acc_next, b_next, psw_next;

    wb_flag_mask u_flag_mask (
        .opcode    (op_q),
        .dest      (dest_q),
        .upd_cy    (upd_cy),
        .upd_ac    (upd_ac),
        .upd_ov    (upd_ov),
        .is_muldiv (is_muldiv)
    );

    always_comb begin
        commit  = (state == ST_COMMIT);
        div_ovf = commit && (op_q == ALU_DIV) && overflow_out;
        wr_acc  = commit && (is_muldiv ? !div_ovf : (dest_q == WB_DEST_ACC));
        wr_b    = commit && (is_muldiv ? !div_ovf : (dest_q == WB_DEST_B));
        wr_psw  = commit && (upd_cy || upd_ac || upd_ov);

        bus_acc  = sfr_we && (sfr_addr == ACC_ADDR);
        bus_b    = sfr_we && (sfr_addr == B_ADDR);
        bus_psw  = sfr_we && (sfr_addr == PSW_ADDR);
        conflict = (bus_acc && wr_acc) || (bus_b && wr_b) || (bus_psw && wr_psw);

        acc_next = acc;
        if (wr_acc)
            acc_next = op_out_1;
        else if (bus_acc)
            acc_next = sfr_wdata;

        b_next = b_reg;
        if (wr_b)
            b_next = is_muldiv ? op_out_2 : op_out_1;
        else if (bus_b)
            b_next = sfr_wdata;

        psw_next = psw;
        if (bus_psw && !wr_psw)
            psw_next = sfr_wdata;
        if (wr_psw) begin
            if (upd_cy) psw_next[PSW_CY] = div_ovf ? 1'b0 : carry_out;
            if (upd_ac) psw_next[PSW_AC] = aux_carry_out;
            if (upd_ov) psw_next[PSW_OV] = div_ovf ? 1'b1 : overflow_out;
        end
        // Parity tracks the ACC value of the next cycle; it is never written directly.
        psw_next[PSW_P] = ^acc_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            op_q         <= ALU_NOP;
            dest_q       <= WB_DEST_ACC;
            addr_q       <= 8'h00;
            acc          <= 8'h00;
            b_reg        <= 8'h00;
            psw          <= 8'h00;
            start_err    <= 1'b0;
            sfr_conflict <= 1'b0;
        end else begin
            acc          <= acc_next;
            b_reg        <= b_next;
            psw          <= psw_next;
            start_err    <= wb_start && (state != ST_IDLE);
            sfr_conflict <= conflict;
            case (state)
                ST_IDLE: begin
                    if (wb_start) begin
                        op_q   <= alu_opcode;
                        dest_q <= wb_dest;
                        addr_q <= wb_addr;
                        cnt    <= op_is_muldiv(alu_opcode)
                                  ? CNT_W'(SETTLE_CYCLES + MULDIV_EXTRA)
                                  : CNT_W'(SETTLE_CYCLES);
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= ST_COMMIT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        carry_in     = psw[PSW_CY];
        aux_carry_in = psw[PSW_AC];
        wb_busy      = (state != ST_IDLE);
        wb_done      = commit && !reset;
        out_we       = commit && !reset && !is_muldiv && (dest_q == WB_DEST_DIRECT);
        out_addr     = out_we ? addr_q : 8'h00;
        out_wdata    = out_we ? op_out_1 : 8'h00;
        fsm_state    = state;
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed-vector bench for alu_writeback with hand-computed expectations.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       wb_start;
    logic [3:0] alu_opcode;
    logic [1:0] wb_dest;
    logic [7:0] wb_addr;
    logic [7:0] op_out_1, op_out_2;
    logic       carry_out, aux_carry_out, overflow_out;
    logic       sfr_we;
    logic [7:0] sfr_addr, sfr_wdata;
    logic [7:0] acc, b_reg, psw;
    logic       carry_in, aux_carry_in;
    logic       out_we;
    logic [7:0] out_addr, out_wdata;
    logic       wb_busy, wb_done, start_err, sfr_conflict;
    wb_state_e  fsm_state;

    int n_vec = 0;
    int n_err = 0;

    int         lat;
    logic       s_we, s_conf;
    logic [7:0] s_addr, s_data;

    alu_writeback dut (
        .clock(clock), .reset(reset), .wb_start(wb_start), .alu_opcode(alu_opcode),
        .wb_dest(wb_dest), .wb_addr(wb_addr), .op_out_1(op_out_1), .op_out_2(op_out_2),
        .carry_out(carry_out), .aux_carry_out(aux_carry_out), .overflow_out(overflow_out),
        .sfr_we(sfr_we), .sfr_addr(sfr_addr), .sfr_wdata(sfr_wdata),
        .acc(acc), .b_reg(b_reg), .psw(psw), .carry_in(carry_in), .aux_carry_in(aux_carry_in),
        .out_we(out_we), .out_addr(out_addr), .out_wdata(out_wdata), .wb_busy(wb_busy),
        .wb_done(wb_done), .start_err(start_err), .sfr_conflict(sfr_conflict),
        .fsm_state(fsm_state)
    );

    // Clock / reset
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Driver tasks
    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        sfr_we = 1'b1; sfr_addr = a; sfr_wdata = d;
        tick();
        sfr_we = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [1:0] dest, input logic [7:0] addr,
                          input logic [7:0] r1, input logic [7:0] r2,
                          input logic cy, input logic ac, input logic ov,
                          input logic bus_we, input logic [7:0] bus_addr, input logic [7:0] bus_data,
                          output int l, output logic we, output logic [7:0] oa,
                          output logic [7:0] od, output logic conf);
        alu_opcode = op; wb_dest = dest; wb_addr = addr; op_out_1 = r1; op_out_2 = r2;
        carry_out = cy; aux_carry_out = ac; overflow_out = ov;
        wb_start = 1'b1;
        l = -1; we = 1'b0; oa = 8'h00; od = 8'h00; conf = 1'b0;
        for (int i = 1; i <= 20 && l < 0; i++) begin
            tick();
            wb_start = 1'b0;
            if (wb_done) begin
                l = i; we = out_we; oa = out_addr; od = out_wdata;
                if (bus_we) begin
                    sfr_we = 1'b1; sfr_addr = bus_addr; sfr_wdata = bus_data;
                end
            end
        end
        if (l >= 0) begin
            tick();
            sfr_we = 1'b0;
            conf = sfr_conflict;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_vec++; if (acc !== 8'h00) begin n_err++; $display("FAIL reset_acc: got %h want 00", acc); end
        n_vec++; if (b_reg !== 8'h00) begin n_err++; $display("FAIL reset_b: got %h want 00", b_reg); end
        n_vec++; if (psw !== 8'h00) begin n_err++; $display("FAIL reset_psw: got %h want 00", psw); end
        n_vec++; if ({wb_busy, wb_done, out_we, start_err, sfr_conflict} !== 5'b0) begin
            n_err++; $display("FAIL reset_strobes: got %b want 00000", {wb_busy, wb_done, out_we, start_err, sfr_conflict}); end
        n_vec++; if (fsm_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
    endtask

    task automatic test_add();
        run_op(ALU_ADD, WB_DEST_ACC, 8'h00, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00,
               lat, s_we, s_addr, s_data, s_conf);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL add_latency: got %0d want 2", lat); end
        n_vec++; if (acc !== 8'h80) begin n_err++; $display("FAIL add_acc: got %h want 80", acc); end
        n_vec++; if (psw !== 8'h45) begin n_err++; $display("FAIL add_psw: got %h want 45", psw); end
        n_vec++; if (aux_carry_in !== 1'b1) begin n_err++; $display("FAIL add_aux_carry_in: got %b want 1", aux_carry_in); end
        n_vec++; if (s_we !== 1'b0) begin n_err++; $display("FAIL add_no_out_we: got %b want 0", s_we); end
    endtask

    task automatic test_mul();
        run_op(ALU_MUL, WB_DEST_FLAGS, 8'h00, 8'h10, 8'h27, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00,
               lat, s_we, s_addr, s_data, s_conf);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL mul_latency: got %0d want 4", lat); end
        n_vec++; if (acc !== 8'h10) begin n_err++; $display("FAIL mul_acc: got %h want 10", acc); end
        n_vec++; if (b_reg !== 8'h27) begin n_err++; $display("FAIL mul_b: got %h want 27", b_reg); end
        // AC kept from the ADD: MUL does not touch it.
        n_vec++; if (psw !== 8'h45) begin n_err++; $display("FAIL mul_psw: got %h want 45", psw); end
    endtask

    task automatic test_div_overflow();
        sfr_write(ACC_ADDR, 8'h55);
        sfr_write(B_ADDR, 8'h33);
        sfr_write(PSW_ADDR, 8'h81);
        n_vec++; if (psw !== 8'h80) begin n_err++; $display("FAIL bus_psw: got %h want 80", psw); end
        n_vec++; if (carry_in !== 1'b1) begin n_err++; $display("FAIL bus_carry_in: got %b want 1", carry_in); end
        run_op(ALU_DIV, WB_DEST_ACC, 8'h00, 8'h99, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00,
               lat, s_we, s_addr, s_data, s_conf);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL div_latency: got %0d want 4", lat); end
        n_vec++; if (acc !== 8'h55) begin n_err++; $display("FAIL div_acc: got %h want 55", acc); end
        n_vec++; if (b_reg !== 8'h33) begin n_err++; $display("FAIL div_b: got %h want 33", b_reg); end
        n_vec++; if (psw !== 8'h04) begin n_err++; $display("FAIL div_psw: got %h want 04", psw); end
    endtask

    task automatic test_rrc_direct();
        run_op(ALU_RRC, WB_DEST_DIRECT, 8'h30, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00,
               lat, s_we, s_addr, s_data, s_conf);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL rrc_latency: got %0d want 2", lat); end
        n_vec++; if ({s_we, s_addr, s_data} !== {1'b1, 8'h30, 8'hA5}) begin
            n_err++; $display("FAIL rrc_out_write: got we=%b addr=%h data=%h want we=1 addr=30 data=a5", s_we, s_addr, s_data); end
        n_vec++; if (out_we !== 1'b0) begin n_err++; $display("FAIL rrc_out_we_pulse: got %b want 0", out_we); end
        n_vec++; if (acc !== 8'h55) begin n_err++; $display("FAIL rrc_acc: got %h want 55", acc); end
        n_vec++; if (psw !== 8'h84) begin n_err++; $display("FAIL rrc_psw: got %h want 84", psw); end
    endtask

    task automatic test_bus_conflict();
        run_op(ALU_ADD, WB_DEST_ACC, 8'h00, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, ACC_ADDR, 8'h11,
               lat, s_we, s_addr, s_data, s_conf);
        n_vec++; if (acc !== 8'h3C) begin n_err++; $display("FAIL conf_acc: got %h want 3c", acc); end
        n_vec++; if (s_conf !== 1'b1) begin n_err++; $display("FAIL conf_acc_pulse: got %b want 1", s_conf); end
        n_vec++; if (psw !== 8'h80) begin n_err++; $display("FAIL conf_psw: got %h want 80", psw); end
        run_op(ALU_ADD, WB_DEST_ACC, 8'h00, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, B_ADDR, 8'h11,
               lat, s_we, s_addr, s_data, s_conf);
        n_vec++; if (acc !== 8'h07) begin n_err++; $display("FAIL disj_acc: got %h want 07", acc); end
        n_vec++; if (b_reg !== 8'h11) begin n_err++; $display("FAIL disj_b: got %h want 11", b_reg); end
        n_vec++; if (s_conf !== 1'b0) begin n_err++; $display("FAIL disj_pulse: got %b want 0", s_conf); end
        n_vec++; if (psw !== 8'h41) begin n_err++; $display("FAIL disj_psw: got %h want 41", psw); end
    endtask

    task automatic test_logic_flags();
        run_op(ALU_ORL, WB_DEST_FLAGS, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, PSW_ADDR, 8'h00,
               lat, s_we, s_addr, s_data, s_conf);
        n_vec++; if (psw !== 8'hC1) begin n_err++; $display("FAIL orl_psw: got %h want c1", psw); end
        n_vec++; if (s_conf !== 1'b1) begin n_err++; $display("FAIL orl_conflict: got %b want 1", s_conf); end
        n_vec++; if (acc !== 8'h07) begin n_err++; $display("FAIL orl_acc: got %h want 07", acc); end
        run_op(ALU_ANL, WB_DEST_ACC, 8'h00, 8'hF0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, PSW_ADDR, 8'h00,
               lat, s_we, s_addr, s_data, s_conf);
        n_vec++; if (acc !== 8'hF0) begin n_err++; $display("FAIL anl_acc: got %h want f0", acc); end
        n_vec++; if (psw !== 8'h00) begin n_err++; $display("FAIL anl_psw: got %h want 00", psw); end
        n_vec++; if (s_conf !== 1'b0) begin n_err++; $display("FAIL anl_conflict: got %b want 0", s_conf); end
    endtask

    task automatic test_start_while_busy();
        int nd, ne;
        alu_opcode = ALU_ADD; wb_dest = WB_DEST_B; wb_addr = 8'h00;
        op_out_1 = 8'h5A; op_out_2 = 8'h00;
        carry_out = 1'b0; aux_carry_out = 1'b0; overflow_out = 1'b0;
        wb_start = 1'b1;
        tick();
        n_vec++; if (wb_busy !== 1'b1) begin n_err++; $display("FAIL busy_high: got %b want 1", wb_busy); end
        wb_dest = WB_DEST_ACC;
        tick();
        wb_start = 1'b0;
        nd = 0; ne = 0;
        repeat (8) begin
            if (wb_done) nd++;
            if (start_err) ne++;
            tick();
        end
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL busy_done_count: got %0d want 1", nd); end
        n_vec++; if (ne !== 1) begin n_err++; $display("FAIL busy_err_count: got %0d want 1", ne); end
        n_vec++; if (b_reg !== 8'h5A) begin n_err++; $display("FAIL busy_b: got %h want 5a", b_reg); end
        n_vec++; if (acc !== 8'hF0) begin n_err++; $display("FAIL busy_acc: got %h want f0", acc); end
    endtask

    task automatic test_reset_in_wait();
        int nd;
        alu_opcode = ALU_MUL; wb_dest = WB_DEST_ACC;
        op_out_1 = 8'hAA; op_out_2 = 8'hBB;
        carry_out = 1'b1; aux_carry_out = 1'b1; overflow_out = 1'b1;
        wb_start = 1'b1;
        tick();
        wb_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nd = 0;
        repeat (6) begin
            if (wb_done) nd++;
            tick();
        end
        n_vec++; if ({acc, b_reg, psw} !== 24'h0) begin
            n_err++; $display("FAIL rst_wait_regs: got %h %h %h want 00 00 00", acc, b_reg, psw); end
        n_vec++; if (wb_busy !== 1'b0) begin n_err++; $display("FAIL rst_wait_busy: got %b want 0", wb_busy); end
        n_vec++; if (nd !== 0) begin n_err++; $display("FAIL rst_wait_done: got %0d want 0", nd); end
    endtask

    initial begin
        reset = 1'b0; wb_start = 1'b0; alu_opcode = ALU_NOP; wb_dest = WB_DEST_ACC; wb_addr = 8'h00;
        op_out_1 = 8'h00; op_out_2 = 8'h00; carry_out = 1'b0; aux_carry_out = 1'b0; overflow_out = 1'b0;
        sfr_we = 1'b0; sfr_addr = 8'h00; sfr_wdata = 8'h00;
        test_reset();
        test_add();
        test_mul();
        test_div_overflow();
        test_rrc_direct();
        test_bus_conflict();
        test_logic_flags();
        test_start_while_busy();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Stage directly downstream of the 8051 ALU core.
- Sequences each ALU operation: waits for the combinational result to settle (extra cycles for MUL/DIV), then commits results and flags into ACC, B and PSW, or emits a direct-SFR write.
- Maintains the parity flag and feeds CY/AC back to the ALU as carry_in/aux_carry_in.
- Arbitrates against direct SFR writes arriving from the internal bus.

Parameters:
- SETTLE_CYCLES, 1, cycles between wb_start and result capture for all opcodes.
- MULDIV_EXTRA, 2, additional capture delay for ALU_MUL/ALU_DIV (models the 4-cycle 8051 MUL/DIV).

Ports:
- clock  in  1  single system clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- wb_start  in  1  one-cycle pulse; launches an operation using alu_opcode/wb_dest/wb_addr.
- alu_opcode  in  4  opcode also driving the ALU; held stable by the controller while wb_busy.
- wb_dest  in  2  0=ACC, 1=B, 2=DIRECT (via sfr_out port), 3=FLAGS_ONLY.
- wb_addr  in  8  direct address used when wb_dest=DIRECT.
- op_out_1, op_out_2  in  8 each  ALU results.
- carry_out, aux_carry_out, overflow_out  in  1 each  ALU flags.
- sfr_we  in  1  bus write strobe; sfr_addr in 8; sfr_wdata in 8.
- acc, b_reg, psw  out  8 each  architectural registers.
- carry_in, aux_carry_in  out  1 each  psw[7], psw[6] fed back to the ALU.
- out_we  out  1  one-cycle direct write strobe; out_addr out 8; out_wdata out 8.
- wb_busy  out  1  high from the cycle after wb_start until COMMIT completes.
- wb_done  out  1  one-cycle pulse in the COMMIT cycle.
- start_err, sfr_conflict  out  1 each  one-cycle error pulses.

Behaviour:
- Reset (sync): acc=b_reg=psw=0x00, all strobes and pulses 0, state IDLE, counter 0. Reset mid-operation aborts it and commits nothing.
- FSM IDLE -> WAIT -> COMMIT -> IDLE.
  - wb_start in IDLE loads counter = SETTLE_CYCLES, plus MULDIV_EXTRA when the opcode is MUL/DIV.
  - WAIT decrements the counter and moves to COMMIT when the counter reaches 1.
  - COMMIT lasts exactly 1 cycle.
- Latency: with defaults, wb_done occurs 2 cycles after wb_start (4 for MUL/DIV), and register values are visible in the following cycle.
- wb_start while busy: ignored, start_err pulses, and the current operation is unaffected.
- Commit rules in the COMMIT cycle, by wb_dest:
  - ACC: acc<=op_out_1.
  - B: b_reg<=op_out_1.
  - DIRECT: out_we=1, out_addr=wb_addr, out_wdata=op_out_1.
  - FLAGS_ONLY: no data write.
- MUL: acc<=op_out_1 and b_reg<=op_out_2, regardless of wb_dest.
- DIV: acc<=op_out_1 and b_reg<=op_out_2 regardless of wb_dest, unless overflow_out=1 (divide by zero); then acc and b_reg are unchanged, OV=1, CY=0.
- Flag mask (flags outside the mask are unchanged):
  - ADD/ADDC/SUBB update CY, AC, OV.
  - MUL/DIV update CY, OV.
  - RRC/RLC update CY.
  - ORL/ANL update CY only when wb_dest=FLAGS_ONLY.
  - All other opcodes update no flags.
- Parity psw[0] always equals the XOR reduction of the acc value that will be present next cycle. It updates in the same cycle as any acc write; it is never writable directly.
- Bus writes (sfr_we): address 0xE0 writes acc, 0xF0 writes b_reg, 0xD0 writes psw[7:1] (bit 0 is recomputed). Other addresses are ignored by this block.
- Bus write in the same cycle as COMMIT:
  - If the bus write targets a register the commit writes (including PSW when any flag is masked in), the commit wins, the bus write is dropped and sfr_conflict pulses.
  - If the targets are disjoint, both take effect.
- Bus writes during WAIT are accepted normally. carry_in changes are visible to the ALU immediately.

Decomposition:
- Shared 8051_define.v gains:
  - SFR address constants ACC_ADDR=8'hE0, B_ADDR=8'hF0, PSW_ADDR=8'hD0.
  - PSW bit indices CY=7, AC=6, OV=2, P=0.
  - WB_DEST_* encodings.
- Existing ALU_* opcode defines are reused unchanged.
- One natural sub-module, wb_flag_mask: combinational opcode -> {upd_cy, upd_ac, upd_ov, is_muldiv}.

Test Plan:
- ADD, wb_dest=ACC, op_out_1=0x80, carry_out=0, aux_carry_out=1, overflow_out=1 -> wb_done at start+2; acc=0x80, psw=0x45 (AC, OV, P=1).
- MUL, op_out_1=0x10, op_out_2=0x27, overflow_out=1 -> wb_done at start+4; acc=0x10, b_reg=0x27, CY=0, OV=1, P=1.
- DIV with overflow_out=1, prior acc=0x55, b_reg=0x33 -> acc=0x55, b_reg=0x33 unchanged, OV=1, CY=0.
- RRC, wb_dest=DIRECT, wb_addr=0x30, op_out_1=0xA5, carry_out=1 -> out_we pulse with addr 0x30 and data 0xA5; CY=1; acc unchanged.
- ADD committing to ACC with a simultaneous sfr_we to 0xE0, data 0x11 -> acc = ALU value and sfr_conflict=1; a repeat with sfr_addr=0xF0 -> b_reg=0x11 and no conflict.
- wb_start pulsed while wb_busy -> start_err pulse and a single wb_done. Reset asserted during WAIT -> all registers 0x00, wb_busy=0, no wb_done.
